avalon_mem_if_arb2: RTL
=======================

// Module: avalon_mem_if_arb2
// PURPOSE
//  Shares one local-memory bank between two AFU-side Avalon-MM masters (m0, m1) in the bank's clock domain.
//  Sits between the mem_afu side of the bank shim and two AFU engines.
//  Round-robin command arbitration; write bursts are atomic; read responses are routed by an in-order tag FIFO.
//  Adds zero latency on the command and response paths (combinational mux, registered control).
// PARAMETERS
//  ADDR_WIDTH       27   word address width
//  DATA_WIDTH       512  data width
//  BURST_CNT_WIDTH  7    burstcount width (max burst = 2**(BURST_CNT_WIDTH-1))
//  RD_FIFO_DEPTH    64   outstanding read commands tracked (power of 2, >=2)
// PORTS
//  clk                 in   1                bank clock
//  reset               in   1                synchronous, active-high
//  mN_waitrequest      out  1                per master N=0,1: stall
//  mN_readdata         out  DATA_WIDTH       per master: read data (shared bus)
//  mN_readdatavalid    out  1                per master: read beat valid
//  mN_address          in   ADDR_WIDTH       per master: command address
//  mN_burstcount       in   BURST_CNT_WIDTH  per master: burst length
//  mN_writedata        in   DATA_WIDTH       per master: write data
//  mN_byteenable       in   DATA_WIDTH/8     per master: byte enables
//  mN_read, mN_write   in   1                per master: command strobes
//  s_*                 mirror of the above toward the bank (directions reversed)
//  mN_cmd_cnt          out  32               per master: accepted-command count (see CONFIGURATION)
// BEHAVIOUR
//  Handshake
//   - A command/beat is accepted when (read|write) && !waitrequest.
//   - s_* command fields = granted master's fields.
//   - Granted master's waitrequest = s_waitrequest. Non-granted waitrequest = 1.
//  Reset values
//   - m*_waitrequest=1, m*_readdatavalid=0, s_read=s_write=0.
//   - State IDLE; last-grant ptr=1 (m0 wins first); tag FIFO empty; beat counters 0.
//  FSM states
//   - IDLE: eligible = master with read|write. Reads are eligible only if the tag FIFO is not full.
//     - One eligible master -> grant it.
//     - Both eligible -> grant the master not equal to last-grant ptr.
//     - Grant is held (registered) while the granted command is stalled by s_waitrequest; no switch mid-stall.
//     - Ptr updates on each accepted command.
//   - WR_BURST: entered when a write with burstcount>1 is accepted.
//     - Grant locked to the writing master; beats_left = burstcount-1.
//     - Each accepted write beat decrements beats_left; at 0 -> IDLE.
//     - Other master is stalled even for reads.
//  Read routing
//   - Each accepted read pushes {id, burstcount} to the tag FIFO.
//   - s_readdatavalid asserts readdatavalid only on the head-id master; readdata is broadcast.
//   - Beat counter increments per valid beat; pop + counter clear on last beat.
//   - Same cycle push on full: push blocked, even if a pop occurs that cycle.
//   - Push and pop on non-full FIFO: both occur.
//  Error conditions
//   - s_readdatavalid with empty FIFO: beat dropped, simulation assertion fires.
//   - burstcount==0: simulation assertion fires; treated as 1.
//  Reset mid-operation: FSM -> IDLE, FIFO flushed, counters cleared next cycle; in-flight responses discarded.
// CONFIGURATION
//  Macro AVALON_MEM_IF_ARB2_STATS_EN
//   - Defined: mN_cmd_cnt counts accepted commands per master (one per read cmd, one per write burst).
//     Wraps at 2**32; cleared on reset.
//   - Undefined: mN_cmd_cnt tied to 0; no counter logic.
// TESTING
//  1. Both masters issue read burstcount=4 in the same cycle after reset
//     -> m0 granted first, m1 next cycle; 4 beats to m0 then 4 to m1.
//  2. m0 write burst of 8 while m1 holds a read pending
//     -> m1 waitrequest=1 for all 8 beats; m1 read granted the cycle after beat 8.
//  3. s_waitrequest=1 for 5 cycles with m1 granted and m0 requesting
//     -> grant stays m1, s_address stable; m0 granted after m1 accepted.
//  4. RD_FIFO_DEPTH=4, 4 reads with no responses
//     -> 5th read stalled; a write from the other master is still accepted; read proceeds after first response completes.
//  5. Assert reset during a write burst with 3 beats left
//     -> next cycle state IDLE, s_write=0, FIFO empty; new m1 read granted.
//  6. STATS_EN build, m0 issues 3 reads and 2 write bursts -> m0_cmd_cnt=5, m1_cmd_cnt=0.

Source files
------------

// File: rtl/avalon_mem_if_arb2.sv
// Two-master round-robin arbiter onto one Avalon-MM memory bank, with in-order read-response routing.
// Optional per-master accepted-command counters: define AVALON_MEM_IF_ARB2_STATS_EN.
module avalon_mem_if_arb2 #(
   parameter int ADDR_WIDTH      = 27,
   parameter int DATA_WIDTH      = 512,
   parameter int BURST_CNT_WIDTH = 7,
   parameter int RD_FIFO_DEPTH   = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   output logic                       m0_waitrequest,
   output logic [DATA_WIDTH-1:0]      m0_readdata,
   output logic                       m0_readdatavalid,
   input  logic [ADDR_WIDTH-1:0]      m0_address,
   input  logic [BURST_CNT_WIDTH-1:0] m0_burstcount,
   input  logic [DATA_WIDTH-1:0]      m0_writedata,
   input  logic [DATA_WIDTH/8-1:0]    m0_byteenable,
   input  logic                       m0_read,
   input  logic                       m0_write,
   output logic                       m1_waitrequest,
   output logic [DATA_WIDTH-1:0]      m1_readdata,
   output logic                       m1_readdatavalid,
   input  logic [ADDR_WIDTH-1:0]      m1_address,
   input  logic [BURST_CNT_WIDTH-1:0] m1_burstcount,
   input  logic [DATA_WIDTH-1:0]      m1_writedata,
   input  logic [DATA_WIDTH/8-1:0]    m1_byteenable,
   input  logic                       m1_read,
   input  logic                       m1_write,
   input  logic                       s_waitrequest,
   input  logic [DATA_WIDTH-1:0]      s_readdata,
   input  logic                       s_readdatavalid,
   output logic [ADDR_WIDTH-1:0]      s_address,
   output logic [BURST_CNT_WIDTH-1:0] s_burstcount,
   output logic [DATA_WIDTH-1:0]      s_writedata,
   output logic [DATA_WIDTH/8-1:0]    s_byteenable,
   output logic                       s_read,
   output logic                       s_write,
   output logic [31:0]                m0_cmd_cnt,
   output logic [31:0]                m1_cmd_cnt,
   output logic                       dbg_state
);

   localparam int BCW = BURST_CNT_WIDTH;
   localparam int FAW = $clog2(RD_FIFO_DEPTH);
   localparam logic [BCW-1:0] BC_ONE  = 1;
   localparam logic [FAW:0]   PTR_ONE = 1;

   typedef enum logic {ST_IDLE = 1'b0, ST_WR_BURST = 1'b1} state_t;

   state_t         state, state_nxt;
   logic           last_ptr, hold_valid, hold_id, burst_id;
   logic [BCW-1:0] beats_left, beat_cnt;
   logic [BCW:0]   tag_mem [RD_FIFO_DEPTH];
   logic [FAW:0]   wr_ptr, rd_ptr;
   logic           fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic           head_id, beat_valid;
   logic [BCW-1:0] head_bc;
   logic           elig0, elig1, gnt_valid, gnt_id;
   logic           sel_read, sel_write;
   logic [BCW-1:0] sel_bc, eff_bc;
   logic           rd_acc, wr_acc, cmd_acc;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[FAW] != rd_ptr[FAW]) && (wr_ptr[FAW-1:0] == rd_ptr[FAW-1:0]);
   assign head_id    = tag_mem[rd_ptr[FAW-1:0]][BCW];
   assign head_bc    = tag_mem[rd_ptr[FAW-1:0]][BCW-1:0];

   assign elig0 = m0_write | (m0_read & ~fifo_full);
   assign elig1 = m1_write | (m1_read & ~fifo_full);

   // A locked burst or a stalled command keeps its grant; otherwise round-robin on last_ptr.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_id    = 1'b0;
      if (reset) begin
         gnt_valid = 1'b0;
      end else if (state == ST_WR_BURST) begin
         gnt_valid = 1'b1;
         gnt_id    = burst_id;
      end else if (hold_valid) begin
         gnt_valid = 1'b1;
         gnt_id    = hold_id;
      end else if (elig0 && elig1) begin
         gnt_valid = 1'b1;
         gnt_id    = ~last_ptr;
      end else if (elig0 || elig1) begin
         gnt_valid = 1'b1;
         gnt_id    = elig1;
      end
   end

   assign sel_read     = gnt_id ? m1_read : m0_read;
   assign sel_write    = gnt_id ? m1_write : m0_write;
   assign sel_bc       = gnt_id ? m1_burstcount : m0_burstcount;
   assign eff_bc       = (sel_bc == '0) ? BC_ONE : sel_bc;
   assign s_address    = gnt_id ? m1_address : m0_address;
   assign s_burstcount = sel_bc;
   assign s_writedata  = gnt_id ? m1_writedata : m0_writedata;
   assign s_byteenable = gnt_id ? m1_byteenable : m0_byteenable;

   // Handshake: a command or write beat transfers on a cycle where (read|write) && !waitrequest;
   // the granted master sees s_waitrequest, the other master is held off with waitrequest=1.
   assign s_read         = gnt_valid && (state == ST_IDLE) && sel_read && ~fifo_full;
   assign s_write        = gnt_valid && sel_write;
   assign m0_waitrequest = ~(gnt_valid && ~gnt_id) | s_waitrequest;
   assign m1_waitrequest = ~(gnt_valid && gnt_id) | s_waitrequest;

   assign rd_acc    = s_read & ~s_waitrequest;
   assign wr_acc    = s_write & ~s_waitrequest;
   assign cmd_acc   = rd_acc | wr_acc;
   assign fifo_push = rd_acc & ~fifo_full;

   assign beat_valid       = s_readdatavalid & ~fifo_empty & ~reset;
   assign fifo_pop         = beat_valid && (beat_cnt == head_bc - BC_ONE);
   assign m0_readdata      = s_readdata;
   assign m1_readdata      = s_readdata;
   assign m0_readdatavalid = beat_valid & ~head_id;
   assign m1_readdatavalid = beat_valid & head_id;
   assign dbg_state        = state;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:     if (wr_acc && (eff_bc > BC_ONE)) state_nxt = ST_WR_BURST;
         ST_WR_BURST: if (wr_acc && (beats_left == BC_ONE)) state_nxt = ST_IDLE;
         default:     state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         last_ptr   <= 1'b1;
         hold_valid <= 1'b0;
         hold_id    <= 1'b0;
         burst_id   <= 1'b0;
         beats_left <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         beat_cnt   <= '0;
      end else begin
         state      <= state_nxt;
         hold_valid <= (state == ST_IDLE) && (s_read || s_write) && s_waitrequest;
         hold_id    <= gnt_id;
         if (cmd_acc) last_ptr <= gnt_id;
         if ((state == ST_IDLE) && wr_acc && (eff_bc > BC_ONE)) begin
            burst_id   <= gnt_id;
            beats_left <= eff_bc - BC_ONE;
         end else if ((state == ST_WR_BURST) && wr_acc) begin
            beats_left <= beats_left - BC_ONE;
         end
         if (fifo_push) begin
            tag_mem[wr_ptr[FAW-1:0]] <= {gnt_id, eff_bc};
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (fifo_pop) begin
            rd_ptr   <= rd_ptr + PTR_ONE;
            beat_cnt <= '0;
         end else if (beat_valid) begin
            beat_cnt <= beat_cnt + BC_ONE;
         end
      end
   end

`ifdef AVALON_MEM_IF_ARB2_STATS_EN
   // A write burst counts once, on its first beat.
   always_ff @(posedge clk) begin
      if (reset) begin
         m0_cmd_cnt <= '0;
         m1_cmd_cnt <= '0;
      end else if (cmd_acc && (state == ST_IDLE)) begin
         if (gnt_id) m1_cmd_cnt <= m1_cmd_cnt + 32'd1;
         else        m0_cmd_cnt <= m0_cmd_cnt + 32'd1;
      end
   end
`else
   assign m0_cmd_cnt = '0;
   assign m1_cmd_cnt = '0;
`endif

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(s_readdatavalid && fifo_empty))
            else $error("read beat with no outstanding read tag, beat dropped");
         assert (!(cmd_acc && (state == ST_IDLE) && (sel_bc == '0)))
            else $error("burstcount of 0 accepted, treated as 1");
      end
   end
`endif

endmodule
